// File: rtl/sat_accumulator_ovf.sv
// sat_accumulator_ovf: signed running-sum accumulator at the end of a sample
// stream. Each accepted sample is added into a WIDTH-bit two's-complement
// total; signed overflow either wraps or clamps to MAX/MIN (sat_en), and is
// reported as a per-sample pulse, a held direction bit, a sticky flag and a
// saturating event counter. Every output comes straight from a flop.
//
// Handshake: in_valid is a one-sided valid. The block never back-pressures,
// so every cycle with in_valid=1 consumes in_data (and sat_en) on that rising
// edge. out_valid=1 for exactly one cycle after each accepted sample and marks
// that acc_out/cout/ovf_pulse describe that sample. out_valid=0 means acc_out
// and cout are simply holding.
module sat_accumulator_ovf #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sat_en,
  input  logic             clr,
  output logic [WIDTH-1:0] acc_out,
  output logic             out_valid,
  output logic             cout,
  output logic             ovf_pulse,
  output logic             ovf_dir,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Registered state
  logic [WIDTH-1:0] acc_q,        acc_d;
  logic             out_valid_q,  out_valid_d;
  logic             cout_q,       cout_d;
  logic             ovf_pulse_q,  ovf_pulse_d;
  logic             ovf_dir_q,    ovf_dir_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic [CNT_W-1:0] ovf_count_q,  ovf_count_d;

  // Datapath intermediates
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic             ovf_pos;
  logic [WIDTH-1:0] sat_val;

  // Add at WIDTH+1 bits and classify signed overflow against the stored total.
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, in_data};
    // Like-signed operands whose result sign differs from them overflowed.
    ovf     = (acc_q[WIDTH-1] == in_data[WIDTH-1]) &&
              (sum[WIDTH-1] != acc_q[WIDTH-1]);
    // On overflow both operands share a sign, so acc's sign gives direction.
    ovf_pos = ~acc_q[WIDTH-1];
    sat_val = ovf_pos ? MAX_VAL : MIN_VAL;
  end

  // Next-state selection: clear / clear-and-load / accumulate / hold.
  always_comb begin
    acc_d        = acc_q;
    out_valid_d  = 1'b0;
    cout_d       = cout_q;
    ovf_pulse_d  = 1'b0;
    ovf_dir_d    = ovf_dir_q;
    ovf_sticky_d = ovf_sticky_q;
    ovf_count_d  = ovf_count_q;

    if (clr) begin
      // Clear wipes all status, including the held direction bit. A sample
      // arriving with clr is loaded as-is, so it cannot overflow.
      acc_d        = in_valid ? in_data : '0;
      out_valid_d  = in_valid;
      cout_d       = 1'b0;
      ovf_dir_d    = 1'b0;
      ovf_sticky_d = 1'b0;
      ovf_count_d  = '0;
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      cout_d      = sum[WIDTH];
      acc_d       = (ovf && sat_en) ? sat_val : sum[WIDTH-1:0];
      if (ovf) begin
        ovf_pulse_d  = 1'b1;
        ovf_dir_d    = ovf_pos;
        ovf_sticky_d = 1'b1;
        if (ovf_count_q != CNT_MAX) begin
          ovf_count_d = ovf_count_q + CNT_W'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low reset (overrides clr/in_valid).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      cout_q       <= 1'b0;
      ovf_pulse_q  <= 1'b0;
      ovf_dir_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      cout_q       <= cout_d;
      ovf_pulse_q  <= ovf_pulse_d;
      ovf_dir_q    <= ovf_dir_d;
      ovf_sticky_q <= ovf_sticky_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign acc_out    = acc_q;
  assign out_valid  = out_valid_q;
  assign cout       = cout_q;
  assign ovf_pulse  = ovf_pulse_q;
  assign ovf_dir    = ovf_dir_q;
  assign ovf_sticky = ovf_sticky_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_sat_accumulator_ovf.sv
// Bench for sat_accumulator_ovf at WIDTH=4, CNT_W=2. An integer-arithmetic
// reference model tracks the expected outputs; a compare process checks the
// DUT against it every cycle, and directed steps also check literal values.
module tb_sat_accumulator_ovf;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  localparam int MAXV  = (1 << (WIDTH-1)) - 1;
  localparam int MINV  = -(1 << (WIDTH-1));
  localparam int MODV  = 1 << WIDTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             sat_en = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] acc_out;
  logic             out_valid;
  logic             cout;
  logic             ovf_pulse;
  logic             ovf_dir;
  logic             ovf_sticky;
  logic [CNT_W-1:0] ovf_count;

  always #5 clk = ~clk;

  sat_accumulator_ovf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .sat_en(sat_en), .clr(clr), .acc_out(acc_out), .out_valid(out_valid),
    .cout(cout), .ovf_pulse(ovf_pulse), .ovf_dir(ovf_dir),
    .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // ---------------- reference model ----------------
  int m_acc = 0;   // signed value of the accumulator
  int m_cnt = 0;
  bit m_ov = 0, m_cout = 0, m_pulse = 0, m_dir = 0, m_sticky = 0;

  always @(posedge clk) begin
    int sd, s, u;
    sd = $signed(in_data);
    if (!rst_n) begin
      m_acc = 0; m_cnt = 0; m_ov = 0; m_cout = 0;
      m_pulse = 0; m_dir = 0; m_sticky = 0;
    end else if (clr) begin
      m_acc = in_valid ? sd : 0;
      m_ov = in_valid; m_cout = 0; m_pulse = 0; m_dir = 0;
      m_sticky = 0; m_cnt = 0;
    end else if (in_valid) begin
      s = m_acc + sd;
      u = (m_acc & (MODV-1)) + int'(in_data);
      m_cout = (u >= MODV);
      m_ov = 1;
      m_pulse = 0;
      if (s > MAXV) begin
        m_pulse = 1; m_dir = 1;
        m_acc = sat_en ? MAXV : s - MODV;
      end else if (s < MINV) begin
        m_pulse = 1; m_dir = 0;
        m_acc = sat_en ? MINV : s + MODV;
      end else begin
        m_acc = s;
      end
      if (m_pulse) begin
        m_sticky = 1;
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      end
    end else begin
      m_ov = 0; m_pulse = 0;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    logic [WIDTH-1:0] e_acc;
    logic [CNT_W-1:0] e_cnt;
    if (chk_en) begin
      e_acc = m_acc[WIDTH-1:0];
      e_cnt = m_cnt[CNT_W-1:0];
      checks++;
      if (acc_out !== e_acc || out_valid !== m_ov || cout !== m_cout ||
          ovf_pulse !== m_pulse || ovf_dir !== m_dir ||
          ovf_sticky !== m_sticky || ovf_count !== e_cnt) begin
        failures++;
        $display("FAIL model_cmp t=%0t got acc=%h ov=%b c=%b p=%b d=%b s=%b n=%h exp acc=%h ov=%b c=%b p=%b d=%b s=%b n=%h",
                 $time, acc_out, out_valid, cout, ovf_pulse, ovf_dir, ovf_sticky, ovf_count,
                 e_acc, m_ov, m_cout, m_pulse, m_dir, m_sticky, e_cnt);
      end
    end
  end

  // ---------------- driver ----------------
  // Apply inputs for one edge, then return 1 time unit after that edge.
  task automatic cyc(input logic r, input logic c, input logic v,
                     input logic [WIDTH-1:0] d, input logic s);
    rst_n = r; clr = c; in_valid = v; in_data = d; sat_en = s;
    @(posedge clk);
    #1;
  endtask

  // Literal expectation on all outputs.
  task automatic expect_all(input string name, input logic [WIDTH-1:0] e_acc,
                            input logic e_ov, input logic e_c, input logic e_p,
                            input logic e_d, input logic e_s,
                            input logic [CNT_W-1:0] e_n);
    checks++;
    if (acc_out !== e_acc || out_valid !== e_ov || cout !== e_c ||
        ovf_pulse !== e_p || ovf_dir !== e_d || ovf_sticky !== e_s ||
        ovf_count !== e_n) begin
      failures++;
      $display("FAIL %s got acc=%h ov=%b c=%b p=%b d=%b s=%b n=%h exp acc=%h ov=%b c=%b p=%b d=%b s=%b n=%h",
               name, acc_out, out_valid, cout, ovf_pulse, ovf_dir, ovf_sticky, ovf_count,
               e_acc, e_ov, e_c, e_p, e_d, e_s, e_n);
    end
  endtask

  // ---------------- directed stimulus ----------------
  logic [WIDTH-1:0] mix_d [8] = '{4'h5, 4'h6, 4'h9, 4'h8, 4'hC, 4'h3, 4'h7, 4'h2};
  logic             mix_s [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 4'h0, 0);
    cyc(0, 0, 0, 4'h0, 0);
    chk_en = 1'b1;
    expect_all("reset", 4'h0, 0, 0, 0, 0, 0, 2'd0);

    // Positive overflow, wrap mode
    cyc(1, 1, 1, 4'h7, 0);
    expect_all("clr_load_7", 4'h7, 1, 0, 0, 0, 0, 2'd0);
    cyc(1, 0, 1, 4'h4, 0);
    expect_all("wrap_pos", 4'hB, 1, 0, 1, 1, 1, 2'd1);
    cyc(1, 0, 0, 4'h0, 0);
    expect_all("hold_idle", 4'hB, 0, 0, 0, 1, 1, 2'd1);

    // Positive overflow, saturate mode
    cyc(1, 1, 1, 4'h7, 1);
    cyc(1, 0, 1, 4'h4, 1);
    expect_all("sat_pos", 4'h7, 1, 0, 1, 1, 1, 2'd1);

    // Negative overflow, wrap then saturate
    cyc(1, 1, 1, 4'hF, 0);
    cyc(1, 0, 1, 4'h8, 0);
    expect_all("wrap_neg", 4'h7, 1, 1, 1, 0, 1, 2'd1);
    cyc(1, 1, 1, 4'hF, 1);
    cyc(1, 0, 1, 4'h8, 1);
    expect_all("sat_neg", 4'h8, 1, 1, 1, 0, 1, 2'd1);

    // Carry without overflow leaves status alone
    cyc(1, 1, 1, 4'h7, 1);
    cyc(1, 0, 1, 4'h1, 1);
    expect_all("sat_pos_again", 4'h7, 1, 0, 1, 1, 1, 2'd1);
    cyc(1, 0, 1, 4'hD, 0);
    expect_all("carry_no_ovf", 4'h4, 1, 1, 0, 1, 1, 2'd1);

    // Five saturating overflows in a row; counter clamps at 3
    cyc(1, 1, 1, 4'h7, 1);
    cyc(1, 0, 1, 4'h1, 1);
    expect_all("sat_run_1", 4'h7, 1, 0, 1, 1, 1, 2'd1);
    cyc(1, 0, 1, 4'h1, 1);
    expect_all("sat_run_2", 4'h7, 1, 0, 1, 1, 1, 2'd2);
    cyc(1, 0, 1, 4'h1, 1);
    expect_all("sat_run_3", 4'h7, 1, 0, 1, 1, 1, 2'd3);
    cyc(1, 0, 1, 4'h1, 1);
    expect_all("sat_run_4", 4'h7, 1, 0, 1, 1, 1, 2'd3);
    cyc(1, 0, 1, 4'h1, 1);
    expect_all("sat_run_5", 4'h7, 1, 0, 1, 1, 1, 2'd3);
    cyc(1, 1, 0, 4'h0, 0);
    expect_all("clear", 4'h0, 0, 0, 0, 0, 0, 2'd0);

    // Mixed back-to-back stream, checked by the model each cycle
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, mix_d[i], mix_s[i]);

    // Reset asserted mid-stream discards the sample
    cyc(1, 1, 1, 4'h3, 0);
    cyc(1, 0, 1, 4'h3, 0);
    cyc(0, 0, 1, 4'h3, 0);
    expect_all("reset_midstream", 4'h0, 0, 0, 0, 0, 0, 2'd0);
    cyc(1, 0, 0, 4'h0, 0);
    expect_all("idle_after_reset", 4'h0, 0, 0, 0, 0, 0, 2'd0);

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sat_accumulator_ovf.md
# sat_accumulator_ovf

Parametrised signed accumulator with registered overflow detection, selectable wrap/saturate mode, a sticky overflow flag and an overflow event counter. It extends our combinational 4-bit adder/overflow detector into a clocked, WIDTH-generic datapath block. It sits at the end of a sample stream: each valid input sample is added into a running two's-complement total, and overflow status is reported per cycle and cumulatively.

## Interface
- WIDTH, 8: data and accumulator width in bits, two's complement, ≥ 2.
- CNT_W, 8: overflow event counter width in bits, ≥ 1.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data is valid this cycle and is accumulated.
- in_data  input  WIDTH  signed sample.
- sat_en  input  1  1 = saturate on overflow, 0 = wrap; sampled in the same cycle as in_valid.
- clr  input  1  synchronous clear of the accumulator, sticky flag and counter.
- acc_out  output  WIDTH  registered accumulator value.
- out_valid  output  1  acc_out was updated by an accepted sample on the previous edge.
- cout  output  1  registered unsigned carry-out of the last accepted addition.
- ovf_pulse  output  1  last accepted addition overflowed (one-cycle pulse per sample).
- ovf_dir  output  1  direction of the last overflow: 1 = positive (above max), 0 = negative; holds its value until the next overflow.
- ovf_sticky  output  1  set by any overflow; cleared only by clr or reset.
- ovf_count  output  CNT_W  number of overflows since clear; saturates at all-ones.

## Operation
- The block is always ready; there is no backpressure. Every cycle with in_valid=1 accepts one sample.
- Sum is computed at WIDTH+1 bits: sum = {1'b0,acc} + {1'b0,in_data}. cout = sum[WIDTH].
- Overflow condition: acc[MSB] == in_data[MSB] and sum[WIDTH-1] != acc[MSB].
- Overflow direction is positive when both operands are non-negative, negative when both are negative.
- Next accumulator value:
  - No overflow: sum[WIDTH-1:0].
  - Overflow, sat_en=0: sum[WIDTH-1:0] (wrap).
  - Overflow, sat_en=1: MAX = 0 followed by WIDTH-1 ones if positive; MIN = 1 followed by WIDTH-1 zeros if negative.
- On an overflow: ovf_pulse=1, ovf_dir updated, ovf_sticky set, and ovf_count incremented unless it is already all-ones.
- in_valid=0: acc_out and cout hold; out_valid=0; ovf_pulse=0.
- clr=1, in_valid=0: acc_out=0, cout=0, ovf_sticky=0, ovf_count=0, ovf_dir=0, out_valid=0, ovf_pulse=0.
- clr=1 and in_valid=1 in the same cycle (clear-and-load): acc_out=in_data, cout=0, out_valid=1, no overflow is possible, ovf_pulse=0, and the sticky flag and counter are cleared.
- rst_n=0 takes priority over clr and in_valid.

## Timing
- Reset values: every output is 0 (acc_out, out_valid, cout, ovf_pulse, ovf_dir, ovf_sticky, ovf_count).
- Latency is 1 cycle: a sample accepted at edge N appears on acc_out with out_valid=1 and its flags after edge N. ovf_sticky and ovf_count update on the same edge.
- Back-to-back samples are supported at full rate, one sample per cycle, with each addition using the acc value registered on the prior edge.
- Reset asserted mid-stream: the next edge forces all reset values, and samples present during reset are discarded.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan (WIDTH=4, CNT_W=2)
- Reset, then clr+in_valid with in_data=0111 (clear-and-load), then in_valid with in_data=0100, sat_en=0 → acc_out=1011, ovf_pulse=1, ovf_dir=1, cout=0, ovf_sticky=1, ovf_count=01.
- Same sequence with sat_en=1 → acc_out=0111, ovf_pulse=1, ovf_dir=1, ovf_count=01.
- Load acc=1111, add 1000 with sat_en=0 → acc_out=0111, cout=1, ovf_dir=0; with sat_en=1 → acc_out=1000, cout=1, ovf_pulse=1.
- Load acc=0111, add 1101 → acc_out=0100, cout=1, ovf_pulse=0; ovf_sticky and ovf_count unchanged.
- Five consecutive positive overflows in saturate mode (acc=0111, add 0001 each cycle) → acc_out stays at 0111, ovf_pulse=1 on each of the five cycles, ovf_count saturates at 11; then clr → all flags and the counter read 0.
- Stream 0011 for three cycles, assert rst_n=0 on the third → after that edge all outputs are 0; after release, an in_valid=0 cycle keeps out_valid=0.
